bram_rmw_adapter: RTL and testbench

Sits directly upstream of the BRAM controller, between the CPU memory port and the controller's valid/ready memory port. The downstream controller only commits full-word writes (wstrb 4'b1111). This block turns byte and halfword stores into a read-modify-write sequence, forwards reads and full-word writes unchanged, and gives any transfer the controller never acknowledges a bounded completion time.

---
 rtl/mem_bus_pkg.sv | 42 ++++
 rtl/bram_rmw_adapter.sv | 169 ++++++++++++++++
 tb/tb_bram_rmw_adapter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus types and helpers for the CPU-side memory port and
// the slaves hanging off it.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [STRB_W-1:0] WSTRB_READ = 4'b0000;
  localparam logic [STRB_W-1:0] WSTRB_WORD = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    PASS,
    RMW_RD,
    RMW_MRG,
    RMW_WR,
    RESP
  } state_t;

  // One CPU-side request as captured at acceptance.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  // Take each byte lane from new_word where strb is set, else from old_word.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_rmw_adapter.sv
// Converts byte/halfword stores into read-modify-write sequences for a
// full-word-only BRAM controller, with a bounded downstream timeout.
module bram_rmw_adapter
  import mem_bus_pkg::*;
#(
  parameter int unsigned        TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA       = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_mem_valid,
  output logic              s_mem_ready,
  input  logic [ADDR_W-1:0] s_mem_addr,
  input  logic [DATA_W-1:0] s_mem_wdata,
  input  logic [STRB_W-1:0] s_mem_wstrb,
  output logic [DATA_W-1:0] s_mem_rdata,
  output logic              s_mem_err,
  output logic              m_mem_valid,
  input  logic              m_mem_ready,
  output logic [ADDR_W-1:0] m_mem_addr,
  output logic [DATA_W-1:0] m_mem_wdata,
  output logic [STRB_W-1:0] m_mem_wstrb,
  input  logic [DATA_W-1:0] m_mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
  logic                s_ready_q, s_ready_d;
  logic [DATA_W-1:0]   s_rdata_q, s_rdata_d;
  logic                s_err_q, s_err_d;
  logic [DATA_W-1:0]   old_word_q, old_word_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;

  mem_req_t            s_req;
  logic                timed_out;
  logic                unused_addr_lsb;

  assign s_req           = '{addr: s_mem_addr, wdata: s_mem_wdata, wstrb: s_mem_wstrb};
  // Lanes come from wstrb alone; the byte offset is deliberately dropped.
  assign unused_addr_lsb = ^s_req.addr[1:0];

  assign timed_out = (TIMEOUT_CYCLES != 0) && m_valid_q && !m_mem_ready && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;
    s_ready_d  = 1'b0;
    s_err_d    = 1'b0;
    s_rdata_d  = s_rdata_q;
    old_word_d = old_word_q;
    strb_d     = strb_q;
    tmo_d      = tmo_q;

    if (m_valid_q && !m_mem_ready) tmo_d = tmo_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (s_mem_valid) begin
          m_addr_d  = {s_req.addr[ADDR_W-1:2], 2'b00};
          m_wdata_d = s_req.wdata;
          strb_d    = s_req.wstrb;
          m_valid_d = 1'b1;
          tmo_d     = '0;
          if (s_req.wstrb == WSTRB_READ || s_req.wstrb == WSTRB_WORD) begin
            state_d   = PASS;
            m_wstrb_d = s_req.wstrb;
          end else begin
            state_d   = RMW_RD;
            m_wstrb_d = WSTRB_READ;
          end
        end
      end
      PASS: begin
        if (m_mem_ready) begin
          m_valid_d = 1'b0;
          s_rdata_d = (m_wstrb_q == WSTRB_READ) ? m_mem_rdata : m_wdata_q;
          s_ready_d = 1'b1;
          state_d   = RESP;
        end
      end
      RMW_RD: begin
        if (m_mem_ready) begin
          m_valid_d  = 1'b0;
          old_word_d = m_mem_rdata;
          state_d    = RMW_MRG;
        end
      end
      // Valid stays low here so the controller sees two distinct requests.
      RMW_MRG: begin
        m_valid_d = 1'b1;
        m_wstrb_d = WSTRB_WORD;
        m_wdata_d = merge_lanes(old_word_q, m_wdata_q, strb_q);
        tmo_d     = '0;
        state_d   = RMW_WR;
      end
      RMW_WR: begin
        if (m_mem_ready) begin
          m_valid_d = 1'b0;
          s_rdata_d = m_wdata_q;
          s_ready_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase

    // A ready on the final timeout cycle completes normally (timed_out needs !ready).
    if (timed_out) begin
      m_valid_d = 1'b0;
      s_rdata_d = ERR_DATA;
      s_err_d   = 1'b1;
      s_ready_d = 1'b1;
      state_d   = RESP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      s_ready_q  <= 1'b0;
      s_rdata_q  <= '0;
      s_err_q    <= 1'b0;
      old_word_q <= '0;
      strb_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wstrb_q  <= m_wstrb_d;
      s_ready_q  <= s_ready_d;
      s_rdata_q  <= s_rdata_d;
      s_err_q    <= s_err_d;
      old_word_q <= old_word_d;
      strb_q     <= strb_d;
      tmo_q      <= tmo_d;
    end
  end

  assign s_mem_ready = s_ready_q;
  assign s_mem_rdata = s_rdata_q;
  assign s_mem_err   = s_err_q;
  assign m_mem_valid = m_valid_q;
  assign m_mem_addr  = m_addr_q;
  assign m_mem_wdata = m_wdata_q;
  assign m_mem_wstrb = m_wstrb_q;

endmodule

// File: tb/tb_bram_rmw_adapter.sv
// Directed bench for bram_rmw_adapter against a small BRAM controller model
// that raises ready in the fourth cycle of a request.
module tb_bram_rmw_adapter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_mem_valid;
  logic        s_mem_ready;
  logic [31:0] s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [3:0]  s_mem_wstrb;
  logic [31:0] s_mem_rdata;
  logic        s_mem_err;
  logic        m_mem_valid;
  logic        m_mem_ready;
  logic [31:0] m_mem_addr;
  logic [31:0] m_mem_wdata;
  logic [3:0]  m_mem_wstrb;
  logic [31:0] m_mem_rdata;

  int checks = 0;
  int errors = 0;

  // Controller model state
  logic [31:0] mem [0:255];
  logic [1:0]  stub_cnt;
  logic        stall;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata;

  // Per-transfer observations
  logic [31:0] res_rdata;
  logic        res_err;
  int          res_cycles;
  int          res_vhi;
  int          res_gap;
  int          res_addr_bad;
  logic [3:0]  res_wstrb_or;

  bram_rmw_adapter #(.TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_mem_valid (s_mem_valid),
    .s_mem_ready (s_mem_ready),
    .s_mem_addr  (s_mem_addr),
    .s_mem_wdata (s_mem_wdata),
    .s_mem_wstrb (s_mem_wstrb),
    .s_mem_rdata (s_mem_rdata),
    .s_mem_err   (s_mem_err),
    .m_mem_valid (m_mem_valid),
    .m_mem_ready (m_mem_ready),
    .m_mem_addr  (m_mem_addr),
    .m_mem_wdata (m_mem_wdata),
    .m_mem_wstrb (m_mem_wstrb),
    .m_mem_rdata (m_mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mem_ready <= 1'b0;
      m_mem_rdata <= '0;
      stub_cnt    <= '0;
    end else if (m_mem_ready) begin
      m_mem_ready <= 1'b0;
      stub_cnt    <= '0;
    end else if (m_mem_valid && !stall) begin
      if (stub_cnt == 2'd2) begin
        m_mem_ready <= 1'b1;
        m_mem_rdata <= mem[m_mem_addr[9:2]];
        if (m_mem_wstrb == 4'hF) begin
          mem[m_mem_addr[9:2]] <= m_mem_wdata;
          last_wdata <= m_mem_wdata;
          wr_cnt <= wr_cnt + 1;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end else begin
        stub_cnt <= stub_cnt + 2'd1;
      end
    end else begin
      stub_cnt <= '0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1, "watchdog");
  end

  // Issue one request; cycles counts from the request cycle through the ready cycle.
  task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] exp_maddr);
    logic got;
    got = 1'b0;
    res_cycles = 1;
    res_vhi = 0;
    res_gap = 0;
    res_addr_bad = 0;
    res_wstrb_or = '0;
    @(posedge clk); #1;
    s_mem_valid = 1'b1;
    s_mem_addr  = addr;
    s_mem_wdata = wdata;
    s_mem_wstrb = strb;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      res_cycles++;
      if (s_mem_ready) begin
        got = 1'b1;
        break;
      end
      if (m_mem_valid) begin
        res_vhi++;
        res_wstrb_or = res_wstrb_or | m_mem_wstrb;
      end else if (res_vhi > 0) begin
        res_gap++;
      end
      if (m_mem_addr !== exp_maddr) res_addr_bad++;
    end
    res_rdata = s_mem_rdata;
    res_err   = s_mem_err;
    s_mem_valid = 1'b0;
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL xfer_done addr=%h: got no s_mem_ready, need one within 100 cycles", addr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_mem_valid = 1'b0;
    s_mem_addr = '0;
    s_mem_wdata = '0;
    s_mem_wstrb = '0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_mem_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b need=0", s_mem_ready); end
    checks++; if (s_mem_err !== 1'b0) begin errors++; $display("FAIL reset_s_err got=%b need=0", s_mem_err); end
    checks++; if (s_mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_s_rdata got=%h need=0", s_mem_rdata); end
    checks++; if (m_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b need=0", m_mem_valid); end
    checks++; if (m_mem_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr got=%h need=0", m_mem_addr); end
    checks++; if (m_mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_m_wdata got=%h need=0", m_mem_wdata); end
    checks++; if (m_mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_m_wstrb got=%h need=0", m_mem_wstrb); end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_read();
    int rd0, wr0;
    do_xfer(32'h100, 32'h11223344, 4'hF, 32'h100);
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_xfer(32'h100, 32'h0, 4'h0, 32'h100);
    checks++; if (res_rdata !== 32'h11223344) begin errors++; $display("FAIL read_data got=%h need=11223344", res_rdata); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL read_err got=%b need=0", res_err); end
    checks++; if (res_cycles !== 6) begin errors++; $display("FAIL read_latency got=%0d need=6", res_cycles); end
    checks++; if (res_wstrb_or !== 4'h0) begin errors++; $display("FAIL read_m_wstrb got=%h need=0", res_wstrb_or); end
    checks++; if (res_vhi !== 4) begin errors++; $display("FAIL read_valid_cycles got=%0d need=4", res_vhi); end
    checks++; if (res_addr_bad !== 0) begin errors++; $display("FAIL read_addr got=%0d bad cycles need=0", res_addr_bad); end
    checks++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 0) begin errors++; $display("FAIL read_txns got rd=%0d wr=%0d need rd=1 wr=0", rd_cnt - rd0, wr_cnt - wr0); end
    @(posedge clk); #1;
    checks++; if (s_mem_ready !== 1'b0) begin errors++; $display("FAIL ready_pulse_width got=%b need=0", s_mem_ready); end
  endtask

  task automatic test_partial_write();
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_xfer(32'h100, 32'h0000AA00, 4'b0010, 32'h100);
    checks++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1) begin errors++; $display("FAIL rmw_txns got rd=%0d wr=%0d need rd=1 wr=1", rd_cnt - rd0, wr_cnt - wr0); end
    checks++; if (last_wdata !== 32'h1122AA44) begin errors++; $display("FAIL rmw_wdata got=%h need=1122AA44", last_wdata); end
    checks++; if (res_cycles !== 11) begin errors++; $display("FAIL rmw_latency got=%0d need=11", res_cycles); end
    checks++; if (res_rdata !== 32'h1122AA44) begin errors++; $display("FAIL rmw_rdata got=%h need=1122AA44", res_rdata); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL rmw_err got=%b need=0", res_err); end
    do_xfer(32'h100, 32'h0, 4'h0, 32'h100);
    checks++; if (res_rdata !== 32'h1122AA44) begin errors++; $display("FAIL rmw_readback got=%h need=1122AA44", res_rdata); end
  endtask

  task automatic test_full_write();
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_xfer(32'h104, 32'hCAFEBABE, 4'hF, 32'h104);
    checks++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 1) begin errors++; $display("FAIL full_txns got rd=%0d wr=%0d need rd=0 wr=1", rd_cnt - rd0, wr_cnt - wr0); end
    checks++; if (res_cycles !== 6) begin errors++; $display("FAIL full_latency got=%0d need=6", res_cycles); end
    checks++; if (res_rdata !== 32'hCAFEBABE) begin errors++; $display("FAIL full_rdata got=%h need=CAFEBABE", res_rdata); end
    do_xfer(32'h104, 32'h0, 4'h0, 32'h104);
    checks++; if (res_rdata !== 32'hCAFEBABE) begin errors++; $display("FAIL full_readback got=%h need=CAFEBABE", res_rdata); end
  endtask

  task automatic test_halfword();
    do_xfer(32'h100, 32'h11223344, 4'hF, 32'h100);
    do_xfer(32'h102, 32'hBEEF0000, 4'b1100, 32'h100);
    checks++; if (res_addr_bad !== 0) begin errors++; $display("FAIL half_addr_hold got=%0d bad cycles need=0", res_addr_bad); end
    checks++; if (res_gap !== 1) begin errors++; $display("FAIL half_valid_gap got=%0d need=1", res_gap); end
    checks++; if (res_vhi !== 8) begin errors++; $display("FAIL half_valid_cycles got=%0d need=8", res_vhi); end
    checks++; if (mem[8'h40] !== 32'hBEEF3344) begin errors++; $display("FAIL half_mem got=%h need=BEEF3344", mem[8'h40]); end
  endtask

  task automatic test_timeout();
    stall = 1'b1;
    do_xfer(32'h108, 32'h0, 4'h0, 32'h108);
    stall = 1'b0;
    checks++; if (res_vhi !== 8) begin errors++; $display("FAIL tmo_valid_cycles got=%0d need=8", res_vhi); end
    checks++; if (res_cycles !== 10) begin errors++; $display("FAIL tmo_latency got=%0d need=10", res_cycles); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b need=1", res_err); end
    checks++; if (res_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL tmo_rdata got=%h need=DEADBEEF", res_rdata); end
    do_xfer(32'h104, 32'h0, 4'h0, 32'h104);
    checks++; if (res_rdata !== 32'hCAFEBABE || res_err !== 1'b0) begin errors++; $display("FAIL tmo_recover got=%h err=%b need=CAFEBABE err=0", res_rdata, res_err); end
  endtask

  task automatic test_reset_mid_rmw();
    int wr0, vhi, rdy, seen;
    do_xfer(32'h100, 32'h11223344, 4'hF, 32'h100);
    wr0 = wr_cnt; vhi = 0; rdy = 0; seen = 0;
    @(posedge clk); #1;
    s_mem_valid = 1'b1;
    s_mem_addr  = 32'h100;
    s_mem_wdata = 32'h000000FF;
    s_mem_wstrb = 4'b0001;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (m_mem_valid) seen = 1;
      else if (seen == 1) break;
    end
    reset_n = 1'b0;
    s_mem_valid = 1'b0;
    #1;
    checks++; if (m_mem_valid !== 1'b0 || m_mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs got valid=%b wdata=%h need 0/0", m_mem_valid, m_mem_wdata); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (m_mem_valid) vhi++;
      if (s_mem_ready) rdy++;
    end
    checks++; if (vhi !== 0 || rdy !== 0) begin errors++; $display("FAIL rst_mid_quiet got valid=%0d ready=%0d cycles need 0/0", vhi, rdy); end
    checks++; if (wr_cnt - wr0 !== 0) begin errors++; $display("FAIL rst_mid_no_write got=%0d need=0", wr_cnt - wr0); end
    checks++; if (mem[8'h40] !== 32'h11223344) begin errors++; $display("FAIL rst_mid_mem got=%h need=11223344", mem[8'h40]); end
    do_xfer(32'h100, 32'h0, 4'h0, 32'h100);
    checks++; if (res_rdata !== 32'h11223344) begin errors++; $display("FAIL rst_mid_readback got=%h need=11223344", res_rdata); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_partial_write();
    test_full_write();
    test_halfword();
    test_timeout();
    test_reset_mid_rmw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
